// File: rtl/binary_to_gray_counter.sv
// Up/down binary counter with registered Gray-code output, load, optional saturation, terminal-count pulse.
// Latency: 1 clk from en/load sample to outputs; no backpressure (steps whenever en=1).
module binary_to_gray_counter #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               SAT      = (SATURATE != 0);

  logic [WIDTH-1:0] r_binary;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_tc_nxt;

  always_comb begin
    w_bin_nxt = r_binary;
    w_tc_nxt  = 1'b0;
    if (load) begin
      w_bin_nxt = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (r_binary == ALL_ONES) begin
          w_bin_nxt = SAT ? ALL_ONES : '0;
          w_tc_nxt  = 1'b1;
        end else begin
          w_bin_nxt = r_binary + ONE;
        end
      end else begin
        if (r_binary == '0) begin
          w_bin_nxt = SAT ? '0 : ALL_ONES;
          w_tc_nxt  = 1'b1;
        end else begin
          w_bin_nxt = r_binary - ONE;
        end
      end
    end
  end

  // Gray is encoded from the next value so binary and gray land in the same cycle.
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_binary <= '0;
      r_gray   <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_binary <= w_bin_nxt;
      r_gray   <= w_gray_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  assign binary = r_binary;
  assign gray   = r_gray;
  assign tc     = r_tc;

endmodule
